ilkn_test_sequencer: RTL and testbench

Parametrised top-level test sequencer for the Interlaken latency bench. It drives the shared `sys_reset`, the restart pulse and the PM tick for NUM_CORES exdes instances, and reduces their status LEDs into a single run state. It runs NUM_ROUNDS send/receive rounds, measures per-round cycle latency, and detects failures and watchdog timeouts. It sits in the FPGA top, between `init_clk`/`clk_reset` and the core instances.

---
 rtl/ilkn_seq_pkg.sv | 35 +++
 rtl/ilkn_test_sequencer_if.sv | 43 ++++
 rtl/ilkn_seq_watchdog.sv | 30 +++
 rtl/ilkn_test_sequencer.sv | 152 +++++++++++++++
 tb/tb_ilkn_test_sequencer.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ilkn_seq_pkg.sv
// ilkn_seq_pkg: state encodings, fail codes and state-window helpers
// shared by the Interlaken test sequencer and its watchdog.
`default_nettype none

package ilkn_seq_pkg;

  typedef enum logic [3:0] {
    ST_GT_LOCK_WAIT   = 4'd0,
    ST_RX_ALIGN_WAIT  = 4'd1,
    ST_PACKET_SEND    = 4'd2,
    ST_PACKET_RECEIVE = 4'd3,
    ST_IDLE_WAIT      = 4'd4,
    ST_RESTART        = 4'd5,
    ST_BUSY_WAIT      = 4'd6,
    ST_DONE           = 4'd7,
    ST_FAIL           = 4'd8
  } seq_state_e;

  localparam logic [1:0] FC_NONE      = 2'd0;
  localparam logic [1:0] FC_TX_FAIL   = 2'd1;
  localparam logic [1:0] FC_RX_FAILED = 2'd2;
  localparam logic [1:0] FC_TIMEOUT   = 2'd3;

  // Core failure flags are only meaningful once the link is aligned.
  function automatic logic in_fail_window(input seq_state_e s);
    return (s >= ST_PACKET_SEND) && (s <= ST_BUSY_WAIT);
  endfunction

  function automatic logic in_watch_window(input seq_state_e s);
    return (s <= ST_BUSY_WAIT) && (s != ST_RESTART);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ilkn_test_sequencer_if.sv
// ilkn_test_sequencer_if: per-core status inputs and sequencer control/status
// outputs; master = sequencer side, slave = core/observer side.
`default_nettype none

interface ilkn_test_sequencer_if #(
  parameter int NUM_CORES = 2,
  parameter int LAT_W     = 24
);
  logic [NUM_CORES-1:0] tx_done;
  logic [NUM_CORES-1:0] tx_busy;
  logic [NUM_CORES-1:0] tx_fail;
  logic [NUM_CORES-1:0] rx_gt_locked;
  logic [NUM_CORES-1:0] rx_aligned;
  logic [NUM_CORES-1:0] rx_done;
  logic [NUM_CORES-1:0] rx_failed;
  logic [NUM_CORES-1:0] rx_busy;

  logic             sys_reset;
  logic             lbus_tx_rx_restart_in;
  logic             s_axi_pm_tick;
  logic [3:0]       state;
  logic [7:0]       round_cnt;
  logic [LAT_W-1:0] last_latency;
  logic             lat_valid;
  logic             seq_done;
  logic             seq_fail;
  logic [1:0]       fail_code;
  logic [3:0]       fail_state;

  modport master (
    input  tx_done, tx_busy, tx_fail, rx_gt_locked, rx_aligned, rx_done, rx_failed, rx_busy,
    output sys_reset, lbus_tx_rx_restart_in, s_axi_pm_tick, state, round_cnt,
           last_latency, lat_valid, seq_done, seq_fail, fail_code, fail_state
  );

  modport slave (
    output tx_done, tx_busy, tx_fail, rx_gt_locked, rx_aligned, rx_done, rx_failed, rx_busy,
    input  sys_reset, lbus_tx_rx_restart_in, s_axi_pm_tick, state, round_cnt,
           last_latency, lat_valid, seq_done, seq_fail, fail_code, fail_state
  );
endinterface

`default_nettype wire

// File: rtl/ilkn_seq_watchdog.sv
// ilkn_seq_watchdog: per-state cycle counter, cleared on every state change;
// expiry flags the last cycle of TIMEOUT_MAX without progress (ILKN_SEQ_TIMEOUT_EN).
`default_nettype none

module ilkn_seq_watchdog #(
  parameter int TIMEOUT_MAX = 1048575
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  input  wire logic clr_i,
  output logic      expired_o
);
  localparam int CW = $clog2(TIMEOUT_MAX + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (cnt_q != CW'(TIMEOUT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // cnt_q counts completed cycles, so the current cycle is cnt_q+1.
  assign expired_o = (cnt_q >= CW'(TIMEOUT_MAX - 1));

endmodule

`default_nettype wire

// File: rtl/ilkn_test_sequencer.sv
// ilkn_test_sequencer: sequences reset/restart/PM tick for NUM_CORES Interlaken
// exdes cores over NUM_ROUNDS rounds with latency capture; watchdog under ILKN_SEQ_TIMEOUT_EN.
`default_nettype none

module ilkn_test_sequencer
  import ilkn_seq_pkg::*;
#(
  parameter int NUM_CORES   = 2,
  parameter int NUM_ROUNDS  = 2,
  parameter int TIMEOUT_MAX = 1048575,
  parameter int LAT_W       = 24
) (
  input  wire logic             init_clk,
  input  wire logic             clk_reset,
  ilkn_test_sequencer_if.master seq_if
);
  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  seq_state_e           state_q, state_d, adv_state;
  logic                 progress, fail_hit, timeout_hit, wd_expired;
  logic                 entering, rx_edge;
  logic [NUM_CORES-1:0] busy_bits;
  logic                 none_busy, any_fail;

  logic             sys_reset_q, restart_q, restart_d, pm_tick_q, pm_tick_d;
  logic             seq_done_q, seq_done_d, seq_fail_q, seq_fail_d;
  logic             lat_valid_q, lat_valid_d;
  logic [7:0]       round_cnt_q, round_cnt_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d, lat_inc, last_latency_q, last_latency_d;
  logic [1:0]       fail_code_q, fail_code_d;
  logic [3:0]       fail_state_q, fail_state_d;

  assign busy_bits = seq_if.tx_busy | seq_if.rx_busy;
  assign none_busy = ~|busy_bits;
  assign any_fail  = |(seq_if.tx_fail | seq_if.rx_failed);

`ifdef ILKN_SEQ_TIMEOUT_EN
  ilkn_seq_watchdog #(
    .TIMEOUT_MAX(TIMEOUT_MAX)
  ) u_watchdog (
    .clk_i    (init_clk),
    .rst_i    (clk_reset),
    .clr_i    (state_d != state_q),
    .expired_o(wd_expired)
  );
`else
  logic unused_timeout_max;
  assign unused_timeout_max = (TIMEOUT_MAX == 0);
  assign wd_expired         = 1'b0;
`endif

  always_ff @(posedge init_clk) begin
    if (clk_reset) state_q <= ST_GT_LOCK_WAIT;
    else           state_q <= state_d;
  end

  always_comb begin
    progress  = 1'b0;
    adv_state = state_q;
    case (state_q)
      ST_GT_LOCK_WAIT:   begin progress = &seq_if.rx_gt_locked; adv_state = ST_RX_ALIGN_WAIT;  end
      ST_RX_ALIGN_WAIT:  begin progress = &seq_if.rx_aligned;   adv_state = ST_PACKET_SEND;    end
      ST_PACKET_SEND:    begin progress = &seq_if.tx_done;      adv_state = ST_PACKET_RECEIVE; end
      ST_PACKET_RECEIVE: begin progress = &seq_if.rx_done;      adv_state = ST_IDLE_WAIT;      end
      ST_IDLE_WAIT: begin
        progress  = none_busy;
        adv_state = (round_cnt_q == 8'(NUM_ROUNDS)) ? ST_DONE : ST_RESTART;
      end
      ST_RESTART:        begin progress = 1'b1;                 adv_state = ST_BUSY_WAIT;      end
      ST_BUSY_WAIT: begin
        progress  = (&seq_if.tx_busy) && (&seq_if.rx_busy);
        adv_state = ST_PACKET_SEND;
      end
      default: ;
    endcase
    // Failure beats progress, progress beats timeout.
    fail_hit    = in_fail_window(state_q) && any_fail;
    timeout_hit = in_watch_window(state_q) && !progress && wd_expired;
    state_d     = state_q;
    if (fail_hit || timeout_hit) state_d = ST_FAIL;
    else if (progress)           state_d = adv_state;
  end

  always_comb begin
    entering       = (state_d != state_q);
    rx_edge        = (state_q == ST_PACKET_RECEIVE) && (state_d == ST_IDLE_WAIT);
    lat_inc        = (lat_cnt_q == LAT_MAX) ? lat_cnt_q : lat_cnt_q + 1'b1;
    restart_d      = (state_d == ST_RESTART);
    pm_tick_d      = entering && (state_d == ST_DONE);
    seq_done_d     = seq_done_q | pm_tick_d;
    seq_fail_d     = seq_fail_q | (state_d == ST_FAIL);
    round_cnt_d    = rx_edge ? round_cnt_q + 8'd1 : round_cnt_q;
    last_latency_d = rx_edge ? lat_inc : last_latency_q;
    lat_valid_d    = rx_edge;
    lat_cnt_d      = lat_cnt_q;
    if (entering && (state_d == ST_PACKET_SEND)) begin
      lat_cnt_d = '0;
    end else if ((state_q == ST_PACKET_SEND) || (state_q == ST_PACKET_RECEIVE)) begin
      lat_cnt_d = lat_inc;
    end
    fail_code_d  = fail_code_q;
    fail_state_d = fail_state_q;
    if (entering && (state_d == ST_FAIL)) begin
      fail_state_d = state_q;
      if (fail_hit) fail_code_d = (|seq_if.tx_fail) ? FC_TX_FAIL : FC_RX_FAILED;
      else          fail_code_d = FC_TIMEOUT;
    end
  end

  always_ff @(posedge init_clk) begin
    if (clk_reset) begin
      sys_reset_q    <= 1'b1;
      restart_q      <= 1'b0;
      pm_tick_q      <= 1'b0;
      seq_done_q     <= 1'b0;
      seq_fail_q     <= 1'b0;
      lat_valid_q    <= 1'b0;
      round_cnt_q    <= '0;
      lat_cnt_q      <= '0;
      last_latency_q <= '0;
      fail_code_q    <= FC_NONE;
      fail_state_q   <= '0;
    end else begin
      sys_reset_q    <= 1'b0;
      restart_q      <= restart_d;
      pm_tick_q      <= pm_tick_d;
      seq_done_q     <= seq_done_d;
      seq_fail_q     <= seq_fail_d;
      lat_valid_q    <= lat_valid_d;
      round_cnt_q    <= round_cnt_d;
      lat_cnt_q      <= lat_cnt_d;
      last_latency_q <= last_latency_d;
      fail_code_q    <= fail_code_d;
      fail_state_q   <= fail_state_d;
    end
  end

  assign seq_if.sys_reset             = sys_reset_q;
  assign seq_if.lbus_tx_rx_restart_in = restart_q;
  assign seq_if.s_axi_pm_tick         = pm_tick_q;
  assign seq_if.state                 = state_q;
  assign seq_if.round_cnt             = round_cnt_q;
  assign seq_if.last_latency          = last_latency_q;
  assign seq_if.lat_valid             = lat_valid_q;
  assign seq_if.seq_done              = seq_done_q;
  assign seq_if.seq_fail              = seq_fail_q;
  assign seq_if.fail_code             = fail_code_q;
  assign seq_if.fail_state            = fail_state_q;

endmodule

`default_nettype wire

// File: tb/tb_ilkn_test_sequencer.sv
// tb_ilkn_test_sequencer: directed/randomised bench; expectations come from a
// cycle schedule of the core handshakes (latency = cycles in SEND + RECEIVE).
`default_nettype none

module tb_ilkn_test_sequencer;
  localparam int NC  = 2;
  localparam int NR  = 2;
  localparam int TMO = 16;
  localparam int LW  = 24;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_restart = 0;
  int   n_tick = 0;

  always #5 clk = ~clk;

  ilkn_test_sequencer_if #(.NUM_CORES(NC), .LAT_W(LW)) bus ();

  ilkn_test_sequencer #(
    .NUM_CORES(NC), .NUM_ROUNDS(NR), .TIMEOUT_MAX(TMO), .LAT_W(LW)
  ) dut (
    .init_clk (clk),
    .clk_reset(rst),
    .seq_if   (bus)
  );

  always @(negedge clk) begin
    if (bus.lbus_tx_rx_restart_in === 1'b1) n_restart <= n_restart + 1;
    if (bus.s_axi_pm_tick === 1'b1)         n_tick    <= n_tick + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC-1:0] part_mask();
    return NC'($urandom_range(0, (1 << NC) - 2));
  endfunction

  function automatic logic [NC-1:0] nz_mask();
    return NC'($urandom_range(1, (1 << NC) - 1));
  endfunction

  task automatic clear_inputs();
    bus.tx_done = '0; bus.tx_busy = '0; bus.tx_fail = '0; bus.rx_gt_locked = '0;
    bus.rx_aligned = '0; bus.rx_done = '0; bus.rx_failed = '0; bus.rx_busy = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    chk("rst_sys_reset", bus.sys_reset, 1);
    chk("rst_state", bus.state, 0);
    chk("rst_round_lat", {bus.round_cnt, bus.last_latency}, 0);
    chk("rst_flags", {bus.lat_valid, bus.seq_done, bus.seq_fail, bus.fail_code, bus.fail_state,
                      bus.lbus_tx_rx_restart_in, bus.s_axi_pm_tick}, 0);
    rst = 1'b0;
    tick();
    chk("rel_sys_reset", bus.sys_reset, 0);
    chk("rel_state", bus.state, 0);
  endtask

  task automatic to_send();
    int d;
    d = $urandom_range(0, 6);
    bus.rx_gt_locked = part_mask();
    repeat (d) begin tick(); chk("lock_hold", bus.state, 0); end
    bus.rx_gt_locked = '1;
    tick();
    chk("to_align", bus.state, 1);
    d = $urandom_range(0, 6);
    bus.rx_aligned = part_mask();
    repeat (d) begin tick(); chk("align_hold", bus.state, 1); end
    bus.rx_aligned = '1; bus.tx_busy = '1; bus.rx_busy = '1;
    tick();
    chk("to_send", bus.state, 2);
  endtask

  // dt/dr: extra cycles before all tx_done / all rx_done are presented.
  task automatic send_recv(input int dt, input int dr, input int exp_round);
    bus.tx_done = part_mask();
    repeat (dt) begin tick(); chk("send_hold", bus.state, 2); end
    bus.tx_done = '1;
    tick();
    chk("to_recv", bus.state, 3);
    bus.rx_done = part_mask();
    repeat (dr) begin tick(); chk("recv_hold", bus.state, 3); end
    bus.rx_done = '1;
    tick();
    chk("to_idle", bus.state, 4);
    chk("round_cnt", bus.round_cnt, exp_round);
    chk("lat_valid_pulse", bus.lat_valid, 1);
    chk("last_latency", bus.last_latency, dt + dr + 2);
  endtask

  // mode 0: continue into next PACKET_SEND, 1: expect DONE, 2: stop in BUSY_WAIT.
  task automatic idle_phase(input int mode);
    int d;
    bus.tx_done = '0; bus.rx_done = '0; bus.tx_busy = nz_mask(); bus.rx_busy = '0;
    tick();
    chk("idle_hold", bus.state, 4);
    chk("lat_valid_drop", bus.lat_valid, 0);
    d = $urandom_range(0, 4);
    repeat (d) begin tick(); chk("idle_hold", bus.state, 4); end
    bus.tx_busy = '0;
    tick();
    if (mode == 1) begin
      chk("to_done", bus.state, 7);
      chk("pm_tick", bus.s_axi_pm_tick, 1);
      chk("seq_done", bus.seq_done, 1);
      chk("no_restart_done", bus.lbus_tx_rx_restart_in, 0);
      tick();
      chk("pm_tick_drop", bus.s_axi_pm_tick, 0);
      chk("done_hold", bus.state, 7);
    end else begin
      chk("to_restart", bus.state, 5);
      chk("restart_pulse", bus.lbus_tx_rx_restart_in, 1);
      tick();
      chk("to_busy_wait", bus.state, 6);
      chk("restart_drop", bus.lbus_tx_rx_restart_in, 0);
      if (mode == 0) begin
        bus.tx_busy = '1;
        bus.rx_busy = part_mask();
        d = $urandom_range(0, 5);
        repeat (d) begin tick(); chk("busy_hold", bus.state, 6); end
        bus.rx_busy = '1;
        tick();
        chk("busy_to_send", bus.state, 2);
      end
    end
  endtask

  task automatic full_run();
    int rs0, pt0;
    rs0 = n_restart;
    pt0 = n_tick;
    to_send();
    for (int r = 1; r <= NR; r++) begin
      send_recv($urandom_range(0, 6), $urandom_range(0, 6), r);
      idle_phase((r == NR) ? 1 : 0);
    end
    chk("run_restarts", n_restart - rs0, NR - 1);
    chk("run_pm_ticks", n_tick - pt0, 1);
    chk("run_rounds", bus.round_cnt, NR);
    chk("run_no_fail", {bus.seq_fail, bus.fail_code}, 0);
  endtask

  initial begin
    int rs0, pt0;
    rst = 1'b1;
    clear_inputs();

    // Normal two-round run; first round has the 3rd/5th cycle completion pattern.
    do_reset();
    rs0 = n_restart;
    pt0 = n_tick;
    to_send();
    send_recv(2, 4, 1);
    idle_phase(0);
    send_recv($urandom_range(0, 6), $urandom_range(0, 6), 2);
    idle_phase(1);
    chk("restart_count", n_restart - rs0, 1);
    chk("pm_tick_count", n_tick - pt0, 1);
    chk("final_round_cnt", bus.round_cnt, 2);
    chk("final_no_fail", {bus.seq_fail, bus.fail_code}, 0);
    bus.tx_fail = '1;
    repeat (4) tick();
    chk("done_terminal", bus.state, 7);
    chk("done_sticky", {bus.seq_done, bus.seq_fail}, 2'b10);
    chk("done_pm_single", n_tick - pt0, 1);

    // Reset pulsed during BUSY_WAIT, then a clean complete run.
    do_reset();
    to_send();
    send_recv(1, 1, 1);
    idle_phase(2);
    rst = 1'b1;
    tick();
    chk("mid_sys_reset", bus.sys_reset, 1);
    chk("mid_state", bus.state, 0);
    chk("mid_round_cnt", bus.round_cnt, 0);
    chk("mid_latency", bus.last_latency, 0);
    do_reset();
    full_run();

    // Reset on the edge that would have entered RESTART drops the pulse.
    do_reset();
    to_send();
    send_recv(0, 0, 1);
    bus.tx_done = '0; bus.rx_done = '0; bus.tx_busy = nz_mask();
    tick();
    chk("drop_idle", bus.state, 4);
    bus.tx_busy = '0;
    rst = 1'b1;
    rs0 = n_restart;
    tick();
    chk("drop_state", bus.state, 0);
    chk("drop_restart", bus.lbus_tx_rx_restart_in, 0);
    tick();
    chk("drop_no_pulse", n_restart - rs0, 0);

    // tx_fail and rx_failed together in PACKET_RECEIVE: tx_fail wins.
    do_reset();
    to_send();
    bus.tx_done = '1;
    tick();
    chk("f1_recv", bus.state, 3);
    bus.tx_fail = 2'b01;
    bus.rx_failed = 2'b10;
    tick();
    chk("f1_state", bus.state, 8);
    chk("f1_code", bus.fail_code, 1);
    chk("f1_fail_state", bus.fail_state, 3);
    chk("f1_flags", {bus.seq_fail, bus.seq_done}, 2'b10);
    bus.tx_fail = '0; bus.rx_failed = '0; bus.rx_done = '1;
    repeat (3) tick();
    chk("f1_terminal", bus.state, 8);
    chk("f1_code_hold", bus.fail_code, 1);

    // Failure flags ignored before alignment; rx_failed in IDLE_WAIT beats progress.
    do_reset();
    bus.rx_gt_locked = '1;
    bus.tx_fail = nz_mask();
    bus.rx_failed = nz_mask();
    tick();
    chk("f2_align", bus.state, 1);
    repeat (3) begin tick(); chk("f2_ignore", bus.state, 1); end
    bus.tx_fail = '0; bus.rx_failed = '0;
    bus.rx_aligned = '1; bus.tx_busy = '1; bus.rx_busy = '1;
    tick();
    chk("f2_send", bus.state, 2);
    bus.tx_done = '1;
    tick();
    chk("f2_recv", bus.state, 3);
    bus.rx_done = '1;
    tick();
    chk("f2_idle", bus.state, 4);
    bus.tx_busy = '0; bus.rx_busy = '0;
    bus.rx_failed = nz_mask();
    tick();
    chk("f2_state", bus.state, 8);
    chk("f2_code", bus.fail_code, 2);
    chk("f2_fail_state", bus.fail_state, 4);

`ifdef ILKN_SEQ_TIMEOUT_EN
    // One core never locks: FAIL after TMO cycles in GT_LOCK_WAIT.
    do_reset();
    bus.rx_gt_locked = 2'b01;
    repeat (TMO - 2) begin tick(); chk("tmo_hold", bus.state, 0); end
    tick();
    chk("tmo_state", bus.state, 8);
    chk("tmo_code", bus.fail_code, 3);
    chk("tmo_fail_state", bus.fail_state, 0);
    chk("tmo_seq_fail", bus.seq_fail, 1);
`else
    // No watchdog: a stuck alignment blocks indefinitely.
    do_reset();
    bus.rx_gt_locked = '1;
    tick();
    chk("nwd_align", bus.state, 1);
    bus.rx_aligned = 2'b01;
    repeat (3000) tick();
    chk("nwd_state", bus.state, 1);
    chk("nwd_no_fail", {bus.seq_fail, bus.fail_code}, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
